// File: rtl/pio_in_capture_pkg.sv
// pio_in_pkg: shared constants for the pio_in_capture input port.
// Register addresses and edge-mode encodings.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam logic [1:0] ARM_DONE = 2'd3;

endpackage

// File: rtl/pio_in_capture_if.sv
// pio_in_capture_if: Avalon-MM slave bus bundle for pio_in_capture.
// master drives address/chipselect/write_n/writedata, slave returns readdata.
interface pio_in_capture_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_in_filter.sv
// pio_in_filter: one-bit two-flop synchronizer plus optional debounce.
// Ports: clk, reset_n, i_tick (prescaler), i_din (async), o_level.
// Macro PIO_IN_DEBOUNCE_EN adds the debounce counter.
module pio_in_filter
  import pio_in_pkg::*;
#(
  parameter int DEB_COUNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_din,
  output logic o_level
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_COUNT);

  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Counter only runs while the synced input disagrees with
  // the accepted level; the level moves on the tick after the
  // counter has seen DEB_COUNT ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (r_cnt == CNT_MAX) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
`else
  logic w_unused_deb;
  assign w_unused_deb = i_tick ^ (DEB_COUNT != 0);
  assign o_level      = r_sync2;
`endif

endmodule

// File: rtl/pio_in_capture.sv
// pio_in_capture: Avalon-MM input port with edge capture and irq.
// Ports: clk, reset_n, bus (slave), in_port, irq. Macro PIO_IN_DEBOUNCE_EN.
module pio_in_capture
  import pio_in_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int EDGE_MODE  = 0,
  parameter int DEB_DIV    = 1000,
  parameter int DEB_COUNT  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pio_in_capture_if.slave       bus,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] w_level;
  logic [DATA_WIDTH-1:0] w_det;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [DATA_WIDTH-1:0] w_set;
  logic [31:0]           w_rd_mux;
  logic                  w_wr;
  logic                  w_armed;
  logic                  w_tick;
  logic                  w_unused_wd;

  logic [DATA_WIDTH-1:0] r_prev;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_edge;
  logic [1:0]            r_arm_cnt;
  logic [31:0]           r_readdata;
  logic                  r_irq;

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int PW = $clog2(DEB_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DEB_DIV - 1);

  logic [PW-1:0] r_pre;
  logic          r_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else if (r_pre == PRE_MAX) begin
      r_pre  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pre  <= r_pre + PW'(1);
      r_tick <= 1'b0;
    end
  end

  assign w_tick = r_tick;
`else
  logic w_unused_div;
  assign w_unused_div = (DEB_DIV != 0);
  assign w_tick       = 1'b0;
`endif

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
    pio_in_filter #(
      .DEB_COUNT (DEB_COUNT)
    ) u_filt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_tick  (w_tick),
      .i_din   (in_port[gi]),
      .o_level (w_level[gi])
    );
  end

  if (EDGE_MODE == EDGE_FALL) begin : g_fall
    assign w_det = ~w_level & r_prev;
  end else if (EDGE_MODE == EDGE_ANY) begin : g_any
    assign w_det = w_level ^ r_prev;
  end else begin : g_rise
    assign w_det = w_level & ~r_prev;
  end

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_armed     = (r_arm_cnt == ARM_DONE);
  assign w_unused_wd = ^bus.writedata;

  assign w_clr = (w_wr && bus.address == ADDR_EDGE)
               ? bus.writedata[DATA_WIDTH-1:0]
               : '0;
  assign w_set = w_armed ? w_det : '0;

  always_comb begin
    w_rd_mux = '0;
    unique case (1'b1)
      (bus.address == ADDR_DATA):
        w_rd_mux[DATA_WIDTH-1:0] = w_level;
      (bus.address == ADDR_MASK):
        w_rd_mux[DATA_WIDTH-1:0] = r_mask;
      (bus.address == ADDR_EDGE):
        w_rd_mux[DATA_WIDTH-1:0] = r_edge;
      (bus.address == ADDR_STATUS):
        w_rd_mux[1:0] = {w_armed, r_irq};
      default:
        w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_arm_cnt  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_prev     <= w_level;
      r_readdata <= w_rd_mux;
      r_irq      <= |(r_edge & r_mask);
      // Holds off capture while the synchronizer fills from 0.
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end
      if (w_wr && bus.address == ADDR_MASK) begin
        r_mask <= bus.writedata[DATA_WIDTH-1:0];
      end
      // Set is ORed after the clear so a same-cycle edge wins.
      r_edge <= (r_edge & ~w_clr) | w_set;
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = r_irq;

endmodule

// File: tb/tb_pio_in_capture.sv
// tb_pio_in_capture: directed checks of pio_in_capture.
// Rising-edge and any-edge instances share clock and reset.
module tb_pio_in_capture;
  import pio_in_pkg::*;

  typedef struct {
    logic [15:0] inp;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] in_r;
  logic [15:0] in_a;
  logic        irq_r;
  logic        irq_a;
  int          n_pass = 0;
  int          n_chk  = 0;
  vec_t        tbl[$];

  pio_in_capture_if bus_r ();
  pio_in_capture_if bus_a ();

  always #5 clk = ~clk;

  pio_in_capture #(
    .DATA_WIDTH (16),
    .EDGE_MODE  (0),
    .DEB_DIV    (4),
    .DEB_COUNT  (3)
  ) dut_r (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_r),
    .in_port (in_r),
    .irq     (irq_r)
  );

  pio_in_capture #(
    .DATA_WIDTH (16),
    .EDGE_MODE  (2),
    .DEB_DIV    (4),
    .DEB_COUNT  (3)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a),
    .in_port (in_a),
    .irq     (irq_a)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic step(input bit sel,
                      input logic [15:0] inp,
                      input logic wr,
                      input logic [1:0] a,
                      input logic [31:0] wd);
    if (sel) begin
      in_a             = inp;
      bus_a.chipselect = wr;
      bus_a.write_n    = !wr;
      bus_a.address    = a;
      bus_a.writedata  = wd;
    end else begin
      in_r             = inp;
      bus_r.chipselect = wr;
      bus_r.write_n    = !wr;
      bus_r.address    = a;
      bus_r.writedata  = wd;
    end
    @(posedge clk);
    #1;
    bus_r.chipselect = 1'b0;
    bus_r.write_n    = 1'b1;
    bus_a.chipselect = 1'b0;
    bus_a.write_n    = 1'b1;
  endtask

  task automatic vec(input logic [15:0] inp, input logic wr,
                     input logic [1:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic q);
    vec_t v;
    v.inp = inp; v.wr = wr; v.addr = a;
    v.wd = wd; v.rd = rd; v.irq = q;
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int first;
    int bad;
    reset_n          = 1'b0;
    bus_r.chipselect = 1'b0;
    bus_r.write_n    = 1'b1;
    bus_r.address    = 2'd0;
    bus_r.writedata  = '0;
    bus_a.chipselect = 1'b0;
    bus_a.write_n    = 1'b1;
    bus_a.address    = 2'd0;
    bus_a.writedata  = '0;
    in_a             = '0;
`ifdef PIO_IN_DEBOUNCE_EN
    in_r = 16'h0000;
`else
    in_r = 16'hFFFF;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_r", bus_r.readdata, 32'h0);
    check("rst_irq_r", {31'd0, irq_r}, 32'h0);
    check("rst_rd_a", bus_a.readdata, 32'h0);
    check("rst_irq_a", {31'd0, irq_a}, 32'h0);
    reset_n = 1'b1;

`ifdef PIO_IN_DEBOUNCE_EN
    repeat (3) step(0, 16'h0, 0, ADDR_STATUS, 0);
    step(0, 16'h0, 0, ADDR_STATUS, 0);
    check("deb_status", bus_r.readdata, 32'h2);
    for (int i = 0; i < 5; i++) begin
      step(0, 16'h0004, 0, ADDR_DATA, 0);
      check($sformatf("deb_glitch%0d", i), bus_r.readdata, 32'h0);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 16'h0000, 0, ADDR_DATA, 0);
      if (bus_r.readdata != 32'h0) bad++;
    end
    check("deb_glitch_hold", bad, 0);
    first = -1;
    step(0, 16'h0004, 0, ADDR_DATA, 0);
    for (int j = 1; j <= 40; j++) begin
      step(0, 16'h0004, 0, ADDR_DATA, 0);
      if (first < 0 && bus_r.readdata[2]) first = j;
    end
    if (first < 0) $display("FAIL deb_latency: no change in 40 cycles");
    check("deb_lat_range",
          {31'd0, (first >= 14 && first <= 19)}, 32'h1);
    check("deb_final", bus_r.readdata, 32'h4);
`else
    vec(16'hFFFF, 0, ADDR_STATUS, 0,            32'h0,    0);
    vec(16'hFFFF, 0, ADDR_STATUS, 0,            32'h0,    0);
    vec(16'hFFFF, 0, ADDR_STATUS, 0,            32'h0,    0);
    vec(16'hFFFF, 0, ADDR_STATUS, 0,            32'h2,    0);
    vec(16'hFFFF, 0, ADDR_EDGE,   0,            32'h0,    0);
    vec(16'hFFFF, 0, ADDR_DATA,   0,            32'hFFFF, 0);
    vec(16'hFFFE, 1, ADDR_MASK,   32'hFFFF0001, 32'h0,    0);
    vec(16'hFFFE, 0, ADDR_MASK,   0,            32'h1,    0);
    vec(16'hFFFE, 0, ADDR_EDGE,   0,            32'h0,    0);
    vec(16'hFFFE, 0, ADDR_DATA,   0,            32'hFFFE, 0);
    vec(16'hFFFF, 0, ADDR_EDGE,   0,            32'h0,    0);
    vec(16'hFFFF, 0, ADDR_EDGE,   0,            32'h0,    0);
    vec(16'hFFFF, 0, ADDR_EDGE,   0,            32'h0,    0);
    vec(16'hFFFF, 0, ADDR_EDGE,   0,            32'h1,    1);
    vec(16'hFFFE, 0, ADDR_STATUS, 0,            32'h3,    1);
    vec(16'hFFFE, 0, ADDR_EDGE,   0,            32'h1,    1);
    vec(16'hFFFE, 0, ADDR_EDGE,   0,            32'h1,    1);
    vec(16'hFFFE, 0, ADDR_DATA,   0,            32'hFFFE, 1);
    vec(16'hFFFE, 1, ADDR_MASK,   32'h0,        32'h1,    1);
    vec(16'hFFFE, 0, ADDR_EDGE,   0,            32'h1,    0);
    vec(16'hFFFE, 1, ADDR_MASK,   32'h1,        32'h0,    0);
    vec(16'hFFFE, 0, ADDR_EDGE,   0,            32'h1,    1);
    vec(16'hFFFE, 1, ADDR_EDGE,   32'hFFFFFFFE, 32'h1,    1);
    vec(16'hFFFE, 0, ADDR_EDGE,   0,            32'h1,    1);
    vec(16'hFFFE, 1, ADDR_EDGE,   32'h1,        32'h1,    1);
    vec(16'hFFFE, 0, ADDR_EDGE,   0,            32'h0,    0);
    vec(16'hFFFE, 1, ADDR_DATA,   32'hFFFF,     32'hFFFE, 0);
    vec(16'hFFFE, 0, ADDR_DATA,   0,            32'hFFFE, 0);
    vec(16'hFFFE, 1, ADDR_STATUS, 32'hFFFF,     32'h2,    0);
    foreach (tbl[i]) begin
      step(0, tbl[i].inp, tbl[i].wr, tbl[i].addr, tbl[i].wd);
      check($sformatf("v%0d_rd", i), bus_r.readdata, tbl[i].rd);
      check($sformatf("v%0d_irq", i),
            {31'd0, irq_r}, {31'd0, tbl[i].irq});
    end

    step(1, 16'h0000, 1, ADDR_MASK, 32'h20);
    step(1, 16'h0020, 0, ADDR_EDGE, 0);
    step(1, 16'h0020, 0, ADDR_EDGE, 0);
    step(1, 16'h0020, 0, ADDR_EDGE, 0);
    check("any_k2_rd", bus_a.readdata, 32'h0);
    step(1, 16'h0020, 0, ADDR_EDGE, 0);
    check("any_set_rd", bus_a.readdata, 32'h20);
    check("any_set_irq", {31'd0, irq_a}, 32'h1);
    step(1, 16'h0020, 1, ADDR_EDGE, 32'h20);
    check("any_clr_n_irq", {31'd0, irq_a}, 32'h1);
    step(1, 16'h0020, 0, ADDR_EDGE, 0);
    check("any_clr_rd", bus_a.readdata, 32'h0);
    check("any_clr_irq", {31'd0, irq_a}, 32'h0);
    step(1, 16'h0000, 0, ADDR_EDGE, 0);
    step(1, 16'h0000, 0, ADDR_EDGE, 0);
    step(1, 16'h0000, 1, ADDR_EDGE, 32'h20);
    step(1, 16'h0000, 0, ADDR_EDGE, 0);
    check("setwins_rd", bus_a.readdata, 32'h20);
    check("setwins_irq", {31'd0, irq_a}, 32'h1);

    step(0, 16'hFF00, 1, ADDR_MASK, 32'hFFFF);
    repeat (4) step(0, 16'hFF00, 0, ADDR_EDGE, 0);
    check("fall_nocap", bus_r.readdata, 32'h0);
    step(0, 16'hFFFF, 0, ADDR_EDGE, 0);
    repeat (3) step(0, 16'hFFFF, 0, ADDR_EDGE, 0);
    check("pre_rst_edge", bus_r.readdata, 32'h00FF);
    check("pre_rst_irq", {31'd0, irq_r}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd", bus_r.readdata, 32'h0);
    check("mid_rst_irq", {31'd0, irq_r}, 32'h0);
    check("mid_rst_mask", {16'd0, dut_r.r_mask}, 32'h0);
    check("mid_rst_edge", {16'd0, dut_r.r_edge}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(0, 16'hFFFF, 0, ADDR_EDGE, 0);
      check($sformatf("rearm_e%0d", i), bus_r.readdata, 32'h0);
    end
    step(0, 16'hFFFF, 0, ADDR_STATUS, 0);
    check("rearm_status", bus_r.readdata, 32'h2);
    step(0, 16'hFFFF, 0, ADDR_MASK, 0);
    check("rearm_mask", bus_r.readdata, 32'h0);
    repeat (3) step(0, 16'h7FFF, 0, ADDR_EDGE, 0);
    step(0, 16'hFFFF, 0, ADDR_EDGE, 0);
    repeat (3) step(0, 16'hFFFF, 0, ADDR_EDGE, 0);
    check("rearm_cap", bus_r.readdata, 32'h8000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pio_in_capture.md
# pio_in_capture

Parametrised Avalon-MM input port that is the successor to the plain read-only PIO input. It adds:
- a two-flop synchronizer on every input bit;
- per-bit edge capture, selectable as rising, falling or any;
- an interrupt mask and a level interrupt output;
- an optional debounce filter.

It sits on the Qsys system bus as a slave beside the existing PIO blocks. It feeds switch/key inputs to the CPU, either by polling or by interrupt.

## Interface
Parameters:
- DATA_WIDTH, 16: number of input bits, legal range 1..32.
- EDGE_MODE, 0: 0 = rising, 1 = falling, 2 = any edge.
- DEB_DIV, 1000: debounce prescaler period in clk cycles, ≥2. Used only with the debounce feature.
- DEB_COUNT, 4: number of consecutive prescaler ticks a new level must hold before it is accepted, ≥1. Used only with the debounce feature.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  DATA_WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data, zero-extended above DATA_WIDTH.
- irq  out  1  registered level interrupt.

## Operation
Register map (all registers DATA_WIDTH bits; unused upper bits read 0 and ignore writes):
- 0 DATA (RO): filtered input level.
- 1 MASK (RW): interrupt enable per bit.
- 2 EDGE (R/W1C): per-bit captured edge; writing 1 clears that bit.
- 3 STATUS (RO): bit0 = irq, bit1 = armed; other bits 0.

Input path, per bit:
- sync1 → sync2, giving the synchronized level.
- level = sync2 when debounce is compiled out; the debounced value when it is compiled in.
- prev = level delayed one cycle.
- DATA = level.

Edge detect and capture:
- Edge detect per bit: rising = level & ~prev; falling = ~level & prev; any = level ^ prev.
- EDGE bit is set on a detected edge, but only while armed = 1.
- EDGE bit is cleared by a write to address 2 with the corresponding writedata bit = 1.
- Simultaneous set and clear on the same bit in the same cycle: set wins, the bit stays 1.

Arming after reset:
- A 2-bit arm counter counts 0→3 after reset deasserts; armed = (count == 3).
- This suppresses spurious edges while the synchronizer fills from its reset value of 0.

Interrupt and bus behaviour:
- irq register <= |(EDGE & MASK), evaluated each cycle.
- A write occurs when chipselect = 1 and write_n = 0. Writes to addresses 0 and 3 are ignored.
- readdata is updated every cycle from the address mux, independent of chipselect. There is no read side effect.

## Timing
- Reset value of every register and output is 0: readdata, irq, MASK, EDGE, sync1, sync2, prev, arm counter, debounce state.
- in_port change set up before clk edge k (no debounce):
  - sync2 holds the new value after edge k+1;
  - EDGE set after edge k+2;
  - irq asserted after edge k+3.
- readdata shows the register addressed at edge n after edge n, i.e. 1-cycle read latency.
- MASK write at edge n takes effect on irq after edge n+1.
- EDGE clear at edge n deasserts irq after edge n+1, unless the same bit is re-set in that same cycle.
- Reset asserted mid-operation clears everything immediately, asynchronously. Re-arming takes 3 cycles after reset deasserts.

## Configuration
Macro PIO_IN_DEBOUNCE_EN.
- Defined:
  - a shared prescaler produces a 1-cycle tick every DEB_DIV cycles;
  - per bit, a counter of width $clog2(DEB_COUNT+1) increments on each tick while sync2 ≠ level, and resets to 0 whenever sync2 = level;
  - when the counter reaches DEB_COUNT, level <= sync2 and the counter clears.
  - Extra latency is DEB_COUNT to DEB_COUNT+1 ticks.
- Undefined: level = sync2; no prescaler or counters are built.

## Structure
- Package pio_in_pkg contains:
  - address constants ADDR_DATA = 0, ADDR_MASK = 1, ADDR_EDGE = 2, ADDR_STATUS = 3;
  - EDGE_MODE encodings EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
- Sub-module pio_in_filter contains the per-bit synchronizer and, when PIO_IN_DEBOUNCE_EN is defined, the debounce counter. It takes the shared tick as an input. It is instantiated DATA_WIDTH times in a generate loop.
- The top level holds the prescaler, EDGE/MASK registers, arm counter, read mux and irq.

## Test plan
- Reset, DATA_WIDTH = 16, in_port = 16'hFFFF held through reset release:
  - EDGE stays 0 because the edges fall inside the arm window;
  - STATUS reads 0x2 from the 4th cycle after release;
  - DATA reads 0xFFFF.
- EDGE_MODE = 0, MASK = 0x0001, in_port bit0 0→1:
  - EDGE = 0x0001 at k+2; irq = 1 at k+3;
  - a later 1→0 transition leaves EDGE unchanged.
- EDGE_MODE = 2:
  - toggling bit5 sets EDGE bit5;
  - writing 0x20 to address 2 clears it; irq drops one cycle later.
- Write 0x20 to address 2 in the same cycle that bit5 sees a new edge: EDGE bit5 remains 1.
- PIO_IN_DEBOUNCE_EN with DEB_DIV = 4, DEB_COUNT = 3:
  - a 5-cycle glitch on bit2 never changes DATA;
  - a steady change propagates to DATA after 12–16 cycles plus 2 synchronizer cycles.
- Assert reset_n low mid-operation with MASK = 0xFFFF and EDGE = 0x00FF:
  - readdata, irq, MASK and EDGE are all 0 immediately;
  - no edge is captured until 3 cycles after release.
